// File: rtl/cache_controller_param.sv
// 2-way set-associative, write-through, no-write-allocate cache controller with one LRU bit per set.
// Optional macro CACHE_STATS_EN adds saturating read hit/miss counters (hit_count, miss_count).

module cache_controller_param #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 9,
   parameter int WOFF_BITS  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 address,
   input  logic [31:0]                 wdata,
   input  logic                        MEM_R_EN,
   input  logic                        MEM_W_EN,
   output logic [31:0]                 rdata,
   output logic                        ready,
   output logic [31:0]                 sram_address,
   output logic [31:0]                 sram_wdata,
   output logic                        write,
   output logic                        sram_mem_r_en,
   input  logic [(32<<WOFF_BITS)-1:0]  sram_rdata,
   input  logic                        sram_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]                 hit_count,
   output logic [31:0]                 miss_count
`endif
);

   localparam int LINE_W  = 32 << WOFF_BITS;
   localparam int SETS    = 1 << INDEX_BITS;
   localparam int IDX_LSB = WOFF_BITS + 2;
   localparam int TAG_LSB = IDX_LSB + INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR      = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WOFF_BITS-1:0]  woff;
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;

   logic [TAG_BITS-1:0] tag0_q  [SETS];
   logic [TAG_BITS-1:0] tag1_q  [SETS];
   logic [LINE_W-1:0]   data0_q [SETS];
   logic [LINE_W-1:0]   data1_q [SETS];
   logic [SETS-1:0]     valid0_q, valid0_d;
   logic [SETS-1:0]     valid1_q, valid1_d;
   logic [SETS-1:0]     lru_q, lru_d;

   logic              hit0, hit1, hit, hit_way, victim_way;
   logic [LINE_W-1:0] hit_line, upd_line;
   logic [31:0]       hit_word, sram_word;
   logic              fill_en, upd_en, lru_upd, lru_val;
   logic              stat_hit, stat_miss;
   logic              unused_addr;

   assign woff = address[IDX_LSB-1:2];
   assign idx  = address[IDX_LSB +: INDEX_BITS];
   assign tag  = address[TAG_LSB +: TAG_BITS];

   assign unused_addr  = ^address;
   assign sram_address = address;
   assign sram_wdata   = wdata;

   function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                            input logic [WOFF_BITS-1:0] w);
      return line[{w, 5'd0} +: 32];
   endfunction

   // A double match cannot occur in normal operation; way 0 wins if it does.
   assign hit0    = valid0_q[idx] && (tag0_q[idx] == tag);
   assign hit1    = valid1_q[idx] && (tag1_q[idx] == tag);
   assign hit     = hit0 || hit1;
   assign hit_way = !hit0 && hit1;

   assign hit_line  = hit_way ? data1_q[idx] : data0_q[idx];
   assign hit_word  = sel_word(hit_line, woff);
   assign sram_word = sel_word(sram_rdata, woff);

   // Empty ways fill first (way 0 before way 1); otherwise the LRU bit names the victim.
   assign victim_way = !valid0_q[idx] ? 1'b0 :
                       !valid1_q[idx] ? 1'b1 : lru_q[idx];

   always_comb begin
      upd_line = hit_line;
      upd_line[{woff, 5'd0} +: 32] = wdata;
   end

   always_comb begin
      state_d       = state_q;
      ready         = 1'b0;
      rdata         = 32'd0;
      write         = 1'b0;
      sram_mem_r_en = 1'b0;
      fill_en       = 1'b0;
      upd_en        = 1'b0;
      lru_upd       = 1'b0;
      lru_val       = 1'b0;
      stat_hit      = 1'b0;
      stat_miss     = 1'b0;
      case (state_q)
         IDLE: begin
            if (MEM_W_EN) begin
               write   = 1'b1;
               state_d = WR;
            end else if (MEM_R_EN) begin
               if (hit) begin
                  ready    = 1'b1;
                  rdata    = hit_word;
                  lru_upd  = 1'b1;
                  lru_val  = ~hit_way;
                  stat_hit = 1'b1;
               end else begin
                  sram_mem_r_en = 1'b1;
                  state_d       = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            sram_mem_r_en = 1'b1;
            ready         = sram_ready;
            rdata         = sram_word;
            if (sram_ready) begin
               fill_en   = 1'b1;
               lru_upd   = 1'b1;
               lru_val   = ~victim_way;
               stat_miss = 1'b1;
               state_d   = IDLE;
            end
         end
         WR: begin
            write = 1'b1;
            ready = sram_ready;
            if (sram_ready) begin
               state_d = IDLE;
               if (hit) begin
                  upd_en  = 1'b1;
                  lru_upd = 1'b1;
                  lru_val = ~hit_way;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid0_d = valid0_q;
      valid1_d = valid1_q;
      lru_d    = lru_q;
      if (fill_en) begin
         if (victim_way) valid1_d[idx] = 1'b1;
         else            valid0_d[idx] = 1'b1;
      end
      if (lru_upd) lru_d[idx] = lru_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         state_q  <= state_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         lru_q    <= lru_d;
      end
   end

   // Tag/data arrays carry no reset; a reset cycle simply blocks any pending fill or word update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_en && !victim_way) begin
            tag0_q[idx]  <= tag;
            data0_q[idx] <= sram_rdata;
         end
         if (fill_en && victim_way) begin
            tag1_q[idx]  <= tag;
            data1_q[idx] <= sram_rdata;
         end
         if (upd_en && !hit_way) data0_q[idx] <= upd_line;
         if (upd_en && hit_way)  data1_q[idx] <= upd_line;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (stat_hit && (hit_count_q != 32'hFFFF_FFFF))   hit_count_d  = hit_count_q + 32'd1;
      if (stat_miss && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   logic unused_stats;
   assign unused_stats = stat_hit ^ stat_miss;
`endif

endmodule

// File: tb/tb_cache_controller_param.sv
// Self-checking bench for cache_controller_param: scoreboard of expected words, SRAM responder with fixed latency.
// Exercises miss/hit, LRU eviction, write-through, no-write-allocate, reset abort, optional stats.

module tb_cache_controller_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address, wdata;
   logic        MEM_R_EN, MEM_W_EN;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address, sram_wdata;
   logic        write, sram_mem_r_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   cache_controller_param dut (
      .clk           (clk),
      .rst           (rst),
      .address       (address),
      .wdata         (wdata),
      .MEM_R_EN      (MEM_R_EN),
      .MEM_W_EN      (MEM_W_EN),
      .rdata         (rdata),
      .ready         (ready),
      .sram_address  (sram_address),
      .sram_wdata    (sram_wdata),
      .write         (write),
      .sram_mem_r_en (sram_mem_r_en),
      .sram_rdata    (sram_rdata),
      .sram_ready    (sram_ready)
`ifdef CACHE_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One read transaction; SRAM answers 3 cycles after the request cycle.
   task automatic do_read(input string name, input logic [31:0] a, input logic [63:0] line,
                          input logic [31:0] exp_word, input bit exp_hit);
      int ren_cnt, cyc, exp_ren;
      bit done;
      logic [31:0] got, exp_pop;
      exp_q.push_back(exp_word);
      ren_cnt = 0; cyc = 0; done = 0; got = '0;
      @(posedge clk); #1;
      address = a; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; sram_rdata = line; sram_ready = 1'b0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (sram_mem_r_en) ren_cnt++;
         if (ready) begin
            done = 1;
            got  = rdata;
         end else begin
            @(posedge clk); #1;
            sram_ready = (ren_cnt == 3);
            cyc++;
         end
      end
      exp_pop = exp_q.pop_front();
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: ready=0 after %0d cycles, required ready=1", name, cyc);
      end else if (got !== exp_pop) begin
         n_fail++;
         $display("FAIL %s_rdata: got %08h, required %08h", name, got, exp_pop);
      end
      exp_ren = exp_hit ? 0 : 4;
      n_tests++;
      if (ren_cnt !== exp_ren) begin
         n_fail++;
         $display("FAIL %s_sram_r_en_cycles: got %0d, required %0d", name, ren_cnt, exp_ren);
      end
      @(posedge clk); #1;
      MEM_R_EN = 1'b0; sram_ready = 1'b0;
   endtask

   // One write transaction; SRAM answers lat cycles after the request cycle.
   task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                           input int lat, input bit also_read);
      int wr_cnt, rd_cnt, cyc;
      bit done;
      logic [31:0] got_wd, got_addr, exp_pop;
      exp_q.push_back(d);
      wr_cnt = 0; rd_cnt = 0; cyc = 0; done = 0; got_wd = '0;
      @(posedge clk); #1;
      address = a; wdata = d; MEM_W_EN = 1'b1; MEM_R_EN = also_read; sram_ready = 1'b0;
      @(negedge clk);
      got_addr = sram_address;
      while (!done && cyc < 40) begin
         if (write) wr_cnt++;
         if (sram_mem_r_en) rd_cnt++;
         if (ready) begin
            done   = 1;
            got_wd = sram_wdata;
         end else begin
            @(posedge clk); #1;
            sram_ready = (wr_cnt == lat);
            cyc++;
            @(negedge clk);
         end
      end
      exp_pop = exp_q.pop_front();
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: ready=0 after %0d cycles, required ready=1", name, cyc);
      end else if (got_wd !== exp_pop) begin
         n_fail++;
         $display("FAIL %s_sram_wdata: got %08h, required %08h", name, got_wd, exp_pop);
      end
      n_tests++;
      if (got_addr !== a) begin
         n_fail++;
         $display("FAIL %s_sram_address: got %08h, required %08h", name, got_addr, a);
      end
      n_tests++;
      if (wr_cnt !== lat + 1) begin
         n_fail++;
         $display("FAIL %s_write_cycles: got %0d, required %0d", name, wr_cnt, lat + 1);
      end
      n_tests++;
      if (rd_cnt !== 0) begin
         n_fail++;
         $display("FAIL %s_no_read: sram_mem_r_en cycles %0d, required 0", name, rd_cnt);
      end
      @(posedge clk); #1;
      MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; sram_ready = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      @(negedge clk);
      n_tests++;
      if ({ready, write, sram_mem_r_en} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s: ready/write/sram_mem_r_en = %b, required 000", name,
                  {ready, write, sram_mem_r_en});
      end
   endtask

   task automatic check_stats(input string name, input logic [31:0] eh, input logic [31:0] em);
`ifdef CACHE_STATS_EN
      @(negedge clk);
      n_tests++;
      if (hit_count !== eh || miss_count !== em) begin
         n_fail++;
         $display("FAIL %s: hit_count=%0d miss_count=%0d, required %0d/%0d",
                  name, hit_count, miss_count, eh, em);
      end
`else
      if (eh !== em) begin end
      if (name.len() == 0) begin end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      sram_rdata = '0; sram_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle_outputs("reset_outputs");
      check_stats("reset_stats", 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      check_idle_outputs("idle_no_request");
   endtask

   task automatic test_read_miss_hit();
      do_read("miss_0004", 32'h0000_0004, 64'hAAAA_BBBB_CCCC_DDDD, 32'hAAAA_BBBB, 1'b0);
      do_read("hit_0000", 32'h0000_0000, 64'hDEAD_BEEF_DEAD_BEEF, 32'hCCCC_DDDD, 1'b1);
      check_stats("stats_after_miss_hit", 32'd1, 32'd1);
   endtask

   task automatic test_lru_evict();
      do_read("miss_0200", 32'h0000_0200, 64'h2222_2222_2020_2020, 32'h2020_2020, 1'b0);
      do_read("miss_0400", 32'h0000_0400, 64'h4444_4444_4040_4040, 32'h4040_4040, 1'b0);
      do_read("hit_0200", 32'h0000_0200, 64'hDEAD_BEEF_DEAD_BEEF, 32'h2020_2020, 1'b1);
      do_read("evicted_0000", 32'h0000_0000, 64'h0B0B_0B0B_0A0A_0A0A, 32'h0A0A_0A0A, 1'b0);
      do_read("still_0200", 32'h0000_0204, 64'hDEAD_BEEF_DEAD_BEEF, 32'h2222_2222, 1'b1);
      do_read("evicted_0400", 32'h0000_0400, 64'h4444_4444_4040_4040, 32'h4040_4040, 1'b0);
   endtask

   task automatic test_write_through();
      do_write("wr_hit_0200", 32'h0000_0200, 32'h1234_5678, 2, 1'b0);
      do_read("rd_after_wr", 32'h0000_0200, 64'hDEAD_BEEF_DEAD_BEEF, 32'h1234_5678, 1'b1);
      do_read("rd_other_word", 32'h0000_0204, 64'hDEAD_BEEF_DEAD_BEEF, 32'h2222_2222, 1'b1);
      do_write("wr_miss_0600_prio", 32'h0000_0600, 32'hCAFE_F00D, 1, 1'b1);
      do_read("no_alloc_0600", 32'h0000_0600, 64'h6666_6666_6060_6060, 32'h6060_6060, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_read("set1_miss", 32'h0000_000C, 64'h1111_0001_1111_0000, 32'h1111_0001, 1'b0);
      do_read("set1_hit", 32'h0000_0008, 64'hDEAD_BEEF_DEAD_BEEF, 32'h1111_0000, 1'b1);
      do_read("set63_miss", 32'h0000_01F8, 64'h3F3F_0001_3F3F_0000, 32'h3F3F_0000, 1'b0);
   endtask

   task automatic test_reset_mid_miss();
      int ren;
      ren = 0;
      @(posedge clk); #1;
      address = 32'h0000_1004; MEM_R_EN = 1'b1; sram_rdata = 64'h5555_5555_5050_5050;
      sram_ready = 1'b0;
      @(negedge clk); if (sram_mem_r_en) ren++;
      @(posedge clk); #1;
      @(negedge clk); if (sram_mem_r_en) ren++;
      n_tests++;
      if (ren !== 2) begin
         n_fail++;
         $display("FAIL rst_mid_pending: sram_mem_r_en cycles %0d, required 2", ren);
      end
      @(posedge clk); #1;
      rst = 1'b1; sram_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; MEM_R_EN = 1'b0; sram_ready = 1'b0;
      check_idle_outputs("rst_mid_outputs_low");
      check_stats("rst_mid_stats", 32'd0, 32'd0);
      do_read("rst_mid_reread", 32'h0000_1004, 64'h5555_5555_5050_5050, 32'h5555_5555, 1'b0);
      do_read("rst_cleared_0200", 32'h0000_0200, 64'h2222_2222_2020_2020, 32'h2020_2020, 1'b0);
      check_stats("stats_after_rst_reads", 32'd0, 32'd2);
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_lru_evict();
      test_write_through();
      test_back_to_back();
      test_reset_mid_miss();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_controller_param.md
CACHE_CONTROLLER_PARAM -- requirements
Module: cache_controller_param

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, set-index width (2^INDEX_BITS sets).
REQ-002 SHALL have parameter TAG_BITS, default 9, stored tag width.
REQ-003 SHALL have parameter WOFF_BITS, default 1, log2 of 32-bit words per line (LINE_W = 32<<WOFF_BITS).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports address  input  32  byte address; wdata  input  32  write data; MEM_R_EN, MEM_W_EN  input  1  read/write request.
REQ-007 SHALL have ports rdata  output  32  read data; ready  output  1  request complete this cycle.
REQ-008 SHALL have ports sram_address, sram_wdata  output  32  pass-through of address/wdata; write, sram_mem_r_en  output  1  SRAM write/read request.
REQ-009 SHALL have ports sram_rdata  input  LINE_W  full line from SRAM; sram_ready  input  1  SRAM access done.

Function
REQ-010 SHALL decode address as word offset [WOFF_BITS+1:2], index next INDEX_BITS bits, tag next TAG_BITS bits; defaults give index [8:3], tag [17:9].
REQ-011 SHALL implement 2 ways per set, each line holding valid, tag, LINE_W data; one LRU bit per set (0: way 0 least recent).
REQ-012 SHALL run FSM IDLE, RD_MISS, WR; IDLE->WR when MEM_W_EN, else IDLE->RD_MISS when MEM_R_EN and miss; RD_MISS/WR->IDLE on sram_ready.
REQ-013 SHALL give MEM_W_EN priority when MEM_R_EN and MEM_W_EN are both high; read ignored.
REQ-014 SHALL on read hit in IDLE assert ready combinationally same cycle, rdata = selected word of hitting line, no SRAM request, LRU points to other way.
REQ-015 SHALL on read miss assert sram_mem_r_en from the request cycle until and including the sram_ready cycle; ready = sram_ready; rdata = selected word of sram_rdata that cycle.
REQ-016 SHALL on miss completion fill victim way: an invalid way (way 0 first) if any, else the LRU way; write tag, data, valid=1; LRU points to other way.
REQ-017 SHALL write-through: write=1 from request cycle until sram_ready; ready = sram_ready; write never allocates on miss.
REQ-018 SHALL on write completion with hit update only the addressed 32-bit word of the hitting line in place (valid stays 1) and mark that way most recent.
REQ-019 SHALL resolve a two-way match (illegal) in favour of way 0.
REQ-020 SHALL require requester to hold address, wdata and enables stable until ready; behaviour otherwise undefined.
REQ-021 SHALL keep ready, write, sram_mem_r_en low in IDLE with no request.

Reset
REQ-022 SHALL on rst clear all valid and LRU bits and force FSM to IDLE next edge; data/tag arrays need not reset.
REQ-023 SHALL on rst during RD_MISS or WR abandon the access: no fill, no word update, outputs low following cycle.

Configuration
REQ-024 SHALL with CACHE_STATS_EN defined add outputs hit_count, miss_count (32 bits each), reset to 0, incremented on each completed read hit/miss, saturating at 32'hFFFFFFFF.
REQ-025 SHALL without CACHE_STATS_EN omit those ports and counters; all other behaviour identical.

Verification
REQ-026 SHALL cover: reset, read 0x0000_0004 (miss), sram_rdata=64'hAAAA_BBBB_CCCC_DDDD, sram_ready after 3 cycles -> sram_mem_r_en high 4 cycles, rdata=0xAAAA_BBBB with ready.
REQ-027 SHALL cover: repeat read 0x0000_0000 -> ready same cycle, rdata=0xCCCC_DDDD, sram_mem_r_en stays 0.
REQ-028 SHALL cover: reads 0x0000_0000, 0x0000_0200, 0x0000_0400 (same index 0) -> third fill evicts way holding 0x0000 (LRU); re-read 0x0000 misses, 0x0200 hits.
REQ-029 SHALL cover: write 0x0000_0200 data 0x1234_5678 after it is cached -> write high until sram_ready; later read hits returning 0x1234_5678; write to uncached address does not allocate.
REQ-030 SHALL cover: rst asserted mid RD_MISS then read same address -> miss again; with CACHE_STATS_EN, after REQ-026/027 sequence hit_count=1, miss_count=1.
